// File: rtl/tiny_alu.sv
// tiny_alu: 8-bit ALU with start/done handshake; add/and/xor in one cycle, mul over three edges
module tiny_alu (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic [2:0]  op,
  input  logic        start,
  output logic        done,
  output logic [15:0] result
);
  typedef enum logic [1:0] {IDLE, MUL1, MUL2} state_t;
  state_t state, state_n;
  logic [7:0] a_q, b_q;
  logic [15:0] result_n;
  logic done_n, accept, is_mul;
  always_comb begin
    accept = state == IDLE && start && !done && op != 3'd0 && op <= 3'd4;
    is_mul = op == 3'd4;
    state_n = state;
    done_n = 1'b0;
    result_n = result;
    case (state)
      IDLE: begin
        state_n = accept && is_mul ? MUL1 : IDLE;
        done_n = accept && !is_mul;
        result_n = !(accept && !is_mul) ? result :
                   op == 3'd1 ? {7'b0, {1'b0, A} + {1'b0, B}} :
                   op == 3'd2 ? {8'b0, A & B} : {8'b0, A ^ B};
      end
      MUL1: state_n = MUL2;
      MUL2: begin
        state_n = IDLE;
        done_n = 1'b1;
        result_n = {8'b0, a_q} * {8'b0, b_q};
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      done <= 1'b0;
      result <= 16'h0000;
      a_q <= 8'h00;
      b_q <= 8'h00;
    end else begin
      state <= state_n;
      done <= done_n;
      result <= result_n;
      if (accept && is_mul) begin
        a_q <= A;
        b_q <= B;
      end
    end
  end
endmodule

// File: tb/tb_tiny_alu.sv
// tb_tiny_alu: scoreboard bench; expected results queued at drive time, popped on each done pulse
module tb_tiny_alu;
  logic clk = 1'b0;
  logic reset_n;
  logic [7:0] a, b;
  logic [2:0] op;
  logic start;
  logic done;
  logic [15:0] result;
  logic [15:0] sb[$];
  int tests = 0;
  int failed = 0;

  tiny_alu dut (
    .clk(clk), .reset_n(reset_n), .A(a), .B(b), .op(op),
    .start(start), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, input logic s);
    op = o;
    a = x;
    b = y;
    start = s;
  endtask

  // one clock; outputs are sampled on the falling edge after it
  task automatic cyc(input string tag, input logic exp_done);
    @(negedge clk);
    chk({tag, "_done"}, {15'b0, done}, {15'b0, exp_done});
    if (done === 1'b1) begin
      chk({tag, "_sb_empty"}, {15'b0, sb.size() == 0}, 16'd0);
      if (sb.size() != 0) chk({tag, "_result"}, result, sb.pop_front());
    end
  endtask

  initial begin
    reset_n = 1'b0;
    drive(3'd0, 8'h00, 8'h00, 1'b0);
    #1;
    chk("rst_done", {15'b0, done}, 16'd0);
    chk("rst_result", result, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    drive(3'd1, 8'hFF, 8'h01, 1'b1);
    sb.push_back(16'h0100);
    cyc("add_carry", 1'b1);
    drive(3'd0, 8'h00, 8'h00, 1'b0);
    cyc("add_after", 1'b0);
    chk("add_hold", result, 16'h0100);
    drive(3'd2, 8'hF0, 8'h3C, 1'b1);
    sb.push_back(16'h0030);
    cyc("and", 1'b1);
    drive(3'd0, 8'h00, 8'h00, 1'b0);
    cyc("and_after", 1'b0);
    drive(3'd3, 8'hF0, 8'h3C, 1'b1);
    sb.push_back(16'h00CC);
    cyc("xor", 1'b1);
    drive(3'd0, 8'h00, 8'h00, 1'b0);
    cyc("xor_after", 1'b0);
    drive(3'd4, 8'hFF, 8'hFF, 1'b1);
    sb.push_back(16'hFE01);
    cyc("mul_e1", 1'b0);
    a = 8'h00;
    cyc("mul_e2", 1'b0);
    chk("mul_mid_hold", result, 16'h00CC);
    cyc("mul_e3", 1'b1);
    drive(3'd0, 8'h00, 8'h00, 1'b0);
    cyc("mul_after", 1'b0);
    drive(3'd1, 8'h05, 8'h03, 1'b1);
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) sb.push_back(16'h0008);
      cyc("cont_add", i % 2 == 0);
    end
    drive(3'd0, 8'h12, 8'h34, 1'b1);
    for (int i = 0; i < 3; i++) cyc("noop", 1'b0);
    chk("noop_hold", result, 16'h0008);
    drive(3'd6, 8'h12, 8'h34, 1'b1);
    for (int i = 0; i < 3; i++) cyc("reserved", 1'b0);
    chk("reserved_hold", result, 16'h0008);
    drive(3'd4, 8'h10, 8'h10, 1'b1);
    cyc("mulrst_e1", 1'b0);
    start = 1'b0;
    cyc("mulrst_e2", 1'b0);
    reset_n = 1'b0;
    #1;
    chk("mulrst_async_done", {15'b0, done}, 16'd0);
    chk("mulrst_async_result", result, 16'h0000);
    cyc("mulrst_held", 1'b0);
    chk("mulrst_result", result, 16'h0000);
    reset_n = 1'b1;
    cyc("mulrst_release", 1'b0);
    chk("mulrst_no_late", result, 16'h0000);
    drive(3'd1, 8'h01, 8'h02, 1'b1);
    sb.push_back(16'h0003);
    cyc("post_rst_add", 1'b1);
    start = 1'b0;
    cyc("post_rst_after", 1'b0);
    chk("sb_drain", 16'(sb.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
